// File: rtl/ro_freq_meter_if.sv
// ============================================================================
// ro_freq_meter_if : control and result handshake of the ring-oscillator meter
// Revision 1.0
// ============================================================================
`default_nettype none

interface ro_freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] count;
  logic             overflow;

  // master issues requests and consumes results; slave is the meter itself
  modport master (
    output start,
    output abort,
    output result_ready,
    input  busy,
    input  result_valid,
    input  count,
    input  overflow
  );

  modport slave (
    input  start,
    input  abort,
    input  result_ready,
    output busy,
    output result_valid,
    output count,
    output overflow
  );
endinterface

`default_nettype wire

// File: rtl/ro_freq_meter.sv
// ============================================================================
// ro_freq_meter : enables a ring oscillator and counts its edges over a gate
// Revision 1.0
// ============================================================================
`default_nettype none

module ro_freq_meter #(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  wire             clk,
  input  wire             rst_n,
  input  wire             ro_out_i,
  output logic            ro_en_o,
  ro_freq_meter_if.slave  bus
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   edge_det;

  // ro_out is asynchronous; it runs through the synchronizer in every state
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], ro_out_i};
  assign hist_d   = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SETTLE;
          timer_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          state_d = S_GATE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_GATE: begin
        // an edge arriving with the counter already full is lost: flag it
        if (edge_det) begin
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        if (timer_q == GATE_LAST) begin
          state_d = S_DONE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // abort overrides both a pending handshake and any count update
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      timer_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  assign ro_en_o          = (state_q == S_SETTLE) || (state_q == S_GATE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.result_valid = (state_q == S_DONE);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
// ============================================================================
// tb_ro_freq_meter : directed bench with a cycle model of the meter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ro_freq_meter;

  localparam int S       = 16;
  localparam int G       = 1024;
  localparam int SS      = 2;
  localparam int CW      = 16;
  localparam int CNT_MAX = 65535;
  localparam int CW_S    = 4;
  localparam int G_S     = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ro_main  = 1'b0;
  logic ro_small = 1'b0;
  logic ro_en_main;
  logic ro_en_small;

  ro_freq_meter_if #(.CNT_W(CW))   bus_m ();
  ro_freq_meter_if #(.CNT_W(CW_S)) bus_s ();

  ro_freq_meter #(.CNT_W(CW), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro_out_i (ro_main),
    .ro_en_o  (ro_en_main),
    .bus      (bus_m)
  );

  ro_freq_meter #(.CNT_W(CW_S), .GATE_CYCLES(G_S), .SETTLE_CYCLES(S), .SYNC_STAGES(SS)) dut_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro_out_i (ro_small),
    .ro_en_o  (ro_en_small),
    .bus      (bus_s)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ring stimulus: 0 = held low, 1 = held high, 2 = square wave of ro_per clocks
  int ro_mode = 2;
  int ro_per  = 8;
  int ph      = 0;
  initial forever begin
    @(posedge clk);
    #3;
    ph       = ph + 1;
    ro_main  = (ro_mode == 0) ? 1'b0 : (ro_mode == 1) ? 1'b1 : ((ph % ro_per) < (ro_per / 2));
    ro_small = ((ph % 4) < 2);
  end

  // model of the main meter: a measurement starts at cycle t0 and everything
  // else follows from the distance to t0
  bit          m_act  = 1'b0;
  int          t0     = 0;
  int          m_cnt  = 0;
  bit          m_ovf  = 1'b0;
  logic [SS:0] m_hist = '0;
  int          m_rel;
  bit          m_det;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act  = 1'b0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_hist = '0;
    end else begin
      m_rel = cyc - t0;
      m_det = m_hist[SS-1] && !m_hist[SS];
      if (m_act) begin
        if (m_rel > S && m_rel <= S + G && m_det) begin
          if (m_cnt == CNT_MAX) m_ovf = 1'b1;
          else                  m_cnt = m_cnt + 1;
        end
        if (bus_m.abort) begin
          m_act = 1'b0;
          m_cnt = 0;
          m_ovf = 1'b0;
        end else if (m_rel > S + G && bus_m.result_ready) begin
          m_act = 1'b0;
        end
      end else if (bus_m.start) begin
        m_act = 1'b1;
        t0    = cyc;
        m_cnt = 0;
        m_ovf = 1'b0;
      end
      m_hist = {m_hist[SS-1:0], ro_main};
      cyc    = cyc + 1;
    end
  end

  int c_rel;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      c_rel = cyc - t0;
      check("ro_en",        ro_en_main,         32'(m_act && c_rel >= 1 && c_rel <= S + G));
      check("busy",         bus_m.busy,         32'(m_act));
      check("result_valid", bus_m.result_valid, 32'(m_act && c_rel > S + G));
      check("count",        bus_m.count,        m_cnt);
      check("overflow",     bus_m.overflow,     32'(m_ovf));
    end
  end

  task automatic finish_tb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  initial begin
    #1000000;
    n_fail = n_fail + 1;
    $display("FAIL watchdog: simulation time limit reached");
    finish_tb();
  end

  int ts;

  task automatic pulse_start_m();
    @(posedge clk);
    #1;
    bus_m.start = 1'b1;
    ts = cyc;
    @(posedge clk);
    #1;
    bus_m.start = 1'b0;
  endtask

  task automatic wait_valid_m(output int lat, output int en_cycles);
    lat       = -1;
    en_cycles = 0;
    for (int i = 0; i < S + G + 100; i++) begin
      @(negedge clk);
      if (bus_m.result_valid) begin
        lat = cyc - ts;
        break;
      end
      if (ro_en_main) en_cycles = en_cycles + 1;
    end
    if (lat < 0) check("valid_timeout", 0, 1);
  endtask

  task automatic measure(input bit restart, output int lat, output int en_cycles);
    pulse_start_m();
    if (restart) begin
      repeat (S + 10) @(posedge clk);
      #1;
      bus_m.start = 1'b1;
      @(posedge clk);
      #1;
      bus_m.start = 1'b0;
    end
    wait_valid_m(lat, en_cycles);
  endtask

  task automatic handshake_m();
    @(posedge clk);
    #1;
    bus_m.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_m.result_ready = 1'b0;
  endtask

  int lat;
  int en_cyc;
  int lat_s;

  initial begin
    bus_m.start = 1'b0; bus_m.abort = 1'b0; bus_m.result_ready = 1'b0;
    bus_s.start = 1'b0; bus_s.abort = 1'b0; bus_s.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ro_en", ro_en_main, 0);
    check("rst_busy",  bus_m.busy, 0);
    check("rst_valid", bus_m.result_valid, 0);
    check("rst_count", bus_m.count, 0);
    check("rst_ovf",   bus_m.overflow, 0);

    // period-8 ring, result held while ready is low
    measure(1'b0, lat, en_cyc);
    check("lat_basic",   lat, 1041);
    check("count_basic", bus_m.count, 128);
    check("ovf_basic",   bus_m.overflow, 0);
    repeat (20) @(negedge clk);
    check("count_held", bus_m.count, 128);
    check("valid_held", bus_m.result_valid, 1);
    // handshake with a start in the same cycle: start must be ignored
    @(posedge clk);
    #1;
    bus_m.result_ready = 1'b1;
    bus_m.start        = 1'b1;
    @(posedge clk);
    #1;
    bus_m.result_ready = 1'b0;
    bus_m.start        = 1'b0;
    @(negedge clk);
    check("hs_busy",  bus_m.busy, 0);
    check("hs_valid", bus_m.result_valid, 0);
    check("hs_count", bus_m.count, 128);

    // second start inside GATE is dropped
    measure(1'b1, lat, en_cyc);
    check("lat_restart",   lat, 1041);
    check("count_restart", bus_m.count, 128);
    handshake_m();

    // silent ring: low, then high
    ro_mode = 0;
    repeat (10) @(posedge clk);
    measure(1'b0, lat, en_cyc);
    check("count_low",  bus_m.count, 0);
    check("ovf_low",    bus_m.overflow, 0);
    check("ro_en_span", en_cyc, 1040);
    handshake_m();
    ro_mode = 1;
    repeat (10) @(posedge clk);
    measure(1'b0, lat, en_cyc);
    check("count_high", bus_m.count, 0);
    check("ovf_high",   bus_m.overflow, 0);
    handshake_m();
    ro_mode = 2;

    // abort during GATE
    pulse_start_m();
    repeat (S + 50) @(posedge clk);
    #1 bus_m.abort = 1'b1;
    @(posedge clk);
    #1 bus_m.abort = 1'b0;
    @(negedge clk);
    check("abg_ro_en", ro_en_main, 0);
    check("abg_busy",  bus_m.busy, 0);
    check("abg_count", bus_m.count, 0);
    repeat (G + 50) @(negedge clk);
    check("abg_no_valid", bus_m.result_valid, 0);

    // abort during DONE together with ready: abort wins
    measure(1'b0, lat, en_cyc);
    @(posedge clk);
    #1;
    bus_m.abort        = 1'b1;
    bus_m.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_m.abort        = 1'b0;
    bus_m.result_ready = 1'b0;
    @(negedge clk);
    check("abd_valid", bus_m.result_valid, 0);
    check("abd_busy",  bus_m.busy, 0);
    check("abd_count", bus_m.count, 0);
    measure(1'b0, lat, en_cyc);
    check("count_after_abort", bus_m.count, 128);
    handshake_m();

    // asynchronous reset between clock edges mid-GATE
    pulse_start_m();
    repeat (S + 100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_ro_en", ro_en_main, 0);
    check("arst_busy",  bus_m.busy, 0);
    check("arst_valid", bus_m.result_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", bus_m.busy, 0);
    measure(1'b0, lat, en_cyc);
    check("lat_after_rst",   lat, 1041);
    check("count_after_rst", bus_m.count, 128);
    handshake_m();

    // 4-bit counter, period-4 ring over 256 cycles: 64 edges saturate
    @(posedge clk);
    #1 bus_s.start = 1'b1;
    @(posedge clk);
    #1 bus_s.start = 1'b0;
    lat_s = -1;
    for (int i = 0; i < S + G_S + 100; i++) begin
      @(negedge clk);
      if (bus_s.result_valid) begin
        lat_s = i;
        break;
      end
    end
    if (lat_s < 0) check("small_valid_timeout", 0, 1);
    check("small_count", bus_s.count, 15);
    check("small_ovf",   bus_s.overflow, 1);
    @(posedge clk);
    #1 bus_s.result_ready = 1'b1;
    @(posedge clk);
    #1 bus_s.result_ready = 1'b0;
    @(negedge clk);
    check("small_keep_ovf", bus_s.overflow, 1);
    @(posedge clk);
    #1 bus_s.start = 1'b1;
    @(posedge clk);
    #1 bus_s.start = 1'b0;
    @(negedge clk);
    check("small_clr_count", bus_s.count, 0);
    check("small_clr_ovf",   bus_s.overflow, 0);
    check("small_ro_en",     ro_en_small, 1);
    @(posedge clk);
    #1 bus_s.abort = 1'b1;
    @(posedge clk);
    #1 bus_s.abort = 1'b0;
    @(negedge clk);
    check("small_abort_busy", bus_s.busy, 0);

    repeat (5) @(posedge clk);
    finish_tb();
  end

endmodule

`default_nettype wire

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
- Measurement end of the chained inverter delay paths.
- Enables a ring oscillator built around a delay chain, waits a settle time, then counts oscillator rising edges over a fixed window of system-clock cycles.
- Returns the count over a valid/ready result interface.
- Path delay is derived in software as GATE_CYCLES*Tclk/(2*count). This block sits between the ring (ro_en out, ro_out in) and the spy/readout logic.

Parameters:
- CNT_W, 16: width of the edge counter and result.
- GATE_CYCLES, 1024: measurement window length in clk cycles; must be >= 1.
- SETTLE_CYCLES, 16: cycles the ring runs before counting starts; must be >= 1.
- SYNC_STAGES, 2: flip-flop stages in the ro_out synchronizer; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle measurement request; sampled only in IDLE.
- abort  in  1  cancels any in-progress measurement.
- ro_out  in  1  asynchronous ring oscillator output (delay chain result).
- ro_en  out  1  ring enable, driven into the chain's input gating.
- busy  out  1  high in SETTLE, GATE and DONE.
- result_valid  out  1  count holds a finished result.
- result_ready  in  1  consumer accepts the result.
- count  out  CNT_W  rising edges counted in the window.
- overflow  out  1  count saturated during the window.

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. On reset: state=IDLE, ro_en=0, busy=0, result_valid=0, count=0, overflow=0, synchronizer and edge-history flops=0, timers=0.
- ro_out passes through SYNC_STAGES flops, then a 1-flop history register. An edge is detected when sync=1 and hist=0. Both registers update every cycle in every state.
- FSM states: IDLE, SETTLE, GATE, DONE.
- IDLE: start=1 at cycle T -> SETTLE at T+1, with ro_en=1 and busy=1 from T+1. count and overflow clear to 0 on this transition.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then moves to GATE. Edges are not counted.
- GATE: stays exactly GATE_CYCLES cycles. Each cycle with a detected edge increments count. At 2^CNT_W-1 the count holds and overflow is set; overflow is sticky until the next start.
- End of GATE -> DONE. ro_en drops to 0 and result_valid rises in the first DONE cycle, which is T+1+SETTLE_CYCLES+GATE_CYCLES.
- DONE: count, overflow and result_valid hold stable until result_ready=1. On a cycle with result_valid=1 and result_ready=1: -> IDLE, result_valid=0 and busy=0 next cycle; count and overflow keep their values.
- start outside IDLE is ignored, with no queueing. start in the same cycle as the DONE handshake is also ignored.
- abort=1 in SETTLE, GATE or DONE -> IDLE next cycle: ro_en=0, result_valid=0, count=0, overflow=0. abort in IDLE has no effect.
- abort has priority over start and over a simultaneous handshake.
- rst_n low mid-measurement behaves as reset: immediate ro_en=0, no result produced.
- Counting is exact only for ring frequency < clk/2. Faster rings alias; this is a documented limitation, not detected by the block.

Test Plan:
- SETTLE=16, GATE=1024, ro_out square wave with period 8 clk, first rising edge inside SETTLE. Pulse start, hold result_ready=0 -> result_valid rises exactly 1041 cycles after start, count=128, overflow=0. count is held stable until ready=1; busy=0 one cycle after the handshake.
- ro_out held at 0, then held at 1 for a full run -> count=0, overflow=0, ro_en high for exactly 1040 cycles.
- CNT_W=4, ro_out period 4 clk, GATE=256 -> count=15, overflow=1; the next start clears both at SETTLE entry.
- Pulse start again 10 cycles into GATE -> ignored; the single result matches the first scenario.
- abort during GATE, and separately during DONE -> ro_en=0 and busy=0 next cycle, result_valid never/no longer asserted, count=0. A fresh start then yields 128.
- rst_n driven low asynchronously mid-GATE (between clk edges) -> ro_en, busy and result_valid go 0 immediately. After release, the block is idle and a new measurement works.
